// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// uart_rx_param : oversampling UART receiver with a first-word-fall-through FIFO
// Revision      : 1.0
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          baud_tick,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic rx_s;
  logic push, push_ok, pop, full;
  logic perr_set, ferr_set, ovr_set;
  logic ones_odd;

  assign rx_s = sync2_q;

  // Receiver FSM: all timing is counted in baud_tick strobes.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    ones_odd = ^{shreg_q, rx_s};
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            tick_d  = '0;
            state_d = START;
          end
        end
        START: begin
          if (tick_q == HALF_TICK) begin
            tick_d = '0;
            bit_d  = '0;
            // A line that is high again at mid-start was only a glitch.
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == FULL_TICK) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_q == LAST_DATA) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PAR: begin
          if (tick_q == FULL_TICK) begin
            tick_d   = '0;
            bit_d    = '0;
            perr_set = (PARITY == 1) ? ones_odd : !ones_odd;
            state_d  = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == FULL_TICK) begin
            tick_d   = '0;
            ferr_set = !rx_s;
            if (bit_q == LAST_STOP) begin
              bit_d   = '0;
              push    = 1'b1;
              state_d = IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; a push into a full FIFO only survives if a pop frees a slot.
  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = rd_en && (count_q != '0);
    push_ok  = push && (!full || pop);
    ovr_set  = push && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    perr_d = (perr_q && !clr_err) || perr_set;
    ferr_d = (ferr_q && !clr_err) || ferr_set;
    ovr_d  = (ovr_q && !clr_err) || ovr_set;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sync1_q  <= rx;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: rd_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  assign rx_valid   = (count_q != '0);
  assign rd_data    = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_param : directed + randomized bench for three receiver configs
// Revision         : 1.0
// ============================================================================
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Rst       = 1'b0;
  logic baud_tick = 1'b0;
  int   tick_div  = 1;
  int   tdiv_cnt  = 0;

  // baud_tick strobe once every tick_div clocks, updated away from the active edge
  always @(negedge clk) begin
    tdiv_cnt  = (tdiv_cnt + 1) % tick_div;
    baud_tick = (tdiv_cnt == 0);
  end

  logic [2:0] rx_v    = 3'b111;
  logic [2:0] rd_en_v = 3'b000;
  logic [2:0] clr_v   = 3'b000;
  logic [2:0] valid_v, busy_v, perr_v, ferr_v, ovr_v;
  logic [7:0] rd0, rd1;
  logic [8:0] rd2;
  logic [3:0] cnt0, cnt1;
  logic [3:0] cnt2;

  uart_rx_param u_dut0 (
    .clk(clk), .Rst(Rst), .baud_tick(baud_tick), .rx(rx_v[0]), .rd_en(rd_en_v[0]),
    .clr_err(clr_v[0]), .rd_data(rd0), .rx_valid(valid_v[0]), .fifo_count(cnt0[2:0]),
    .busy(busy_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0])
  );

  uart_rx_param #(.PARITY(1)) u_dut1 (
    .clk(clk), .Rst(Rst), .baud_tick(baud_tick), .rx(rx_v[1]), .rd_en(rd_en_v[1]),
    .clr_err(clr_v[1]), .rd_data(rd1), .rx_valid(valid_v[1]), .fifo_count(cnt1[2:0]),
    .busy(busy_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1])
  );

  uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(8), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .Rst(Rst), .baud_tick(baud_tick), .rx(rx_v[2]), .rd_en(rd_en_v[2]),
    .clr_err(clr_v[2]), .rd_data(rd2), .rx_valid(valid_v[2]), .fifo_count(cnt2[2:0]),
    .busy(busy_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2])
  );

  assign cnt0[3] = 1'b0;
  assign cnt1[3] = 1'b0;
  assign cnt2[3] = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_of(input int idx);
    case (idx)
      0:       return {8'h00, rd0};
      1:       return {8'h00, rd1};
      default: return {7'h00, rd2};
    endcase
  endfunction

  function automatic logic [15:0] cnt_of(input int idx);
    case (idx)
      0:       return {12'h000, cnt0};
      1:       return {12'h000, cnt1};
      default: return {12'h000, cnt2};
    endcase
  endfunction

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_tick) k++;
    end
  endtask

  task automatic drive_bit(input int idx, input logic val, input int nticks);
    @(negedge clk);
    rx_v[idx] = val;
    wait_ticks(nticks);
  endtask

  // Serial frame: start, data LSB first, optional parity bit, stop bits, idle gap.
  // pop_at_push raises rd_en on the clock where the last stop bit is sampled
  // (2 synchronizer clocks + 1 detect clock + half a bit, with a tick every clock).
  task automatic send_frame(input int idx, input int os, input int nbits, input logic [8:0] data,
                            input bit has_par, input logic par_bit, input int stop_bits,
                            input logic last_stop, input int last_stop_ticks, input bit pop_at_push);
    drive_bit(idx, 1'b0, os);
    for (int i = 0; i < nbits; i++) drive_bit(idx, data[i], os);
    if (has_par) drive_bit(idx, par_bit, os);
    for (int s = 0; s < stop_bits - 1; s++) drive_bit(idx, 1'b1, os);
    if (pop_at_push) begin
      @(negedge clk);
      rx_v[idx] = 1'b1;
      repeat (os / 2 + 2) @(posedge clk);
      @(negedge clk);
      rd_en_v[idx] = 1'b1;
      @(negedge clk);
      rd_en_v[idx] = 1'b0;
      wait_ticks(os - os / 2 - 3);
    end else begin
      drive_bit(idx, last_stop, last_stop_ticks);
    end
    drive_bit(idx, 1'b1, os);
  endtask

  task automatic pop(input int idx);
    @(negedge clk);
    rd_en_v[idx] = 1'b1;
    @(negedge clk);
    rd_en_v[idx] = 1'b0;
  endtask

  task automatic clear_err(input int idx);
    @(negedge clk);
    clr_v[idx] = 1'b1;
    @(negedge clk);
    clr_v[idx] = 1'b0;
  endtask

  task automatic wait_valid(input int idx, input int budget);
    int n = 0;
    while (!valid_v[idx] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rx_valid_within_budget", valid_v[idx], 1'b1);
  endtask

  logic [8:0] model_q[$];
  logic [8:0] d;
  logic       pbit;
  logic       exp_perr;

  initial begin
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_rx_valid", valid_v[i], 1'b0);
      check("reset_fifo_count", cnt_of(i), 16'd0);
      check("reset_busy", busy_v[i], 1'b0);
      check("reset_rd_data", rd_of(i), 16'd0);
      check("reset_err_flags", {perr_v[i], ferr_v[i], ovr_v[i]}, 3'b000);
    end
    Rst = 1'b1;
    repeat (3) @(negedge clk);

    // Default configuration, 8N1 frame
    send_frame(0, 16, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1, 16, 1'b0);
    wait_valid(0, 50);
    check("a5_rd_data", rd_of(0), 16'h00A5);
    check("a5_fifo_count", cnt_of(0), 16'd1);
    check("a5_busy", busy_v[0], 1'b0);
    check("a5_err_flags", {perr_v[0], ferr_v[0], ovr_v[0]}, 3'b000);
    pop(0);
    check("a5_popped_empty", valid_v[0], 1'b0);

    // Pop on an empty FIFO is ignored
    pop(0);
    check("empty_pop_count", cnt_of(0), 16'd0);

    // Glitch: line low for 3 ticks only
    @(negedge clk);
    rx_v[0] = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    rx_v[0] = 1'b1;
    wait_ticks(40);
    check("false_start_busy", busy_v[0], 1'b0);
    check("false_start_nothing_pushed", cnt_of(0), 16'd0);

    // Stop bit low -> frame error; low stop is shortened so no new start follows
    send_frame(0, 16, 8, 9'h000, 1'b0, 1'b0, 1, 1'b0, 14, 1'b0);
    check("ferr_set", ferr_v[0], 1'b1);
    check("ferr_word_pushed", cnt_of(0), 16'd1);
    check("ferr_rd_data", rd_of(0), 16'h0000);
    check("ferr_no_parity_err", perr_v[0], 1'b0);
    clear_err(0);
    check("ferr_cleared", ferr_v[0], 1'b0);
    pop(0);

    // Even parity config: 0x03 with parity bit 1 is a parity error
    send_frame(1, 16, 8, 9'h003, 1'b1, 1'b1, 1, 1'b1, 16, 1'b0);
    check("par_err_set", perr_v[1], 1'b1);
    check("par_word_pushed", rd_of(1), 16'h0003);
    check("par_no_frame_err", ferr_v[1], 1'b0);
    clear_err(1);
    check("par_err_cleared", perr_v[1], 1'b0);
    pop(1);

    // Random data and parity bits, baud_tick every other clock
    tick_div = 2;
    for (int n = 0; n < 6; n++) begin
      d        = 9'($urandom_range(0, 255));
      pbit     = 1'($urandom_range(0, 1));
      exp_perr = (($countones(d[7:0]) + int'(pbit)) % 2) == 1;
      send_frame(1, 16, 8, d, 1'b1, pbit, 1, 1'b1, 16, 1'b0);
      check("rand_par_rd_data", rd_of(1), {7'h00, d});
      check("rand_par_err", perr_v[1], exp_perr);
      pop(1);
      clear_err(1);
    end
    tick_div = 1;

    // Overrun: five frames into a four-entry FIFO
    for (int n = 1; n <= 5; n++) begin
      d = 9'(n * 17);
      send_frame(0, 16, 8, d, 1'b0, 1'b0, 1, 1'b1, 16, 1'b0);
    end
    check("ovr_set", ovr_v[0], 1'b1);
    check("ovr_fifo_count", cnt_of(0), 16'd4);
    for (int n = 1; n <= 4; n++) begin
      check("ovr_pop_order", rd_of(0), 16'(n * 17));
      pop(0);
    end
    check("ovr_drained", valid_v[0], 1'b0);
    clear_err(0);
    check("ovr_cleared", ovr_v[0], 1'b0);

    // Full FIFO with a pop in the push cycle of 0x66
    model_q.delete();
    for (int n = 0; n < 4; n++) begin
      d = 9'($urandom_range(0, 255));
      model_q.push_back(d);
      send_frame(0, 16, 8, d, 1'b0, 1'b0, 1, 1'b1, 16, 1'b0);
    end
    check("full_before_66", cnt_of(0), 16'd4);
    void'(model_q.pop_front());
    model_q.push_back(9'h066);
    send_frame(0, 16, 8, 9'h066, 1'b0, 1'b0, 1, 1'b1, 16, 1'b1);
    check("push_pop_full_overrun", ovr_v[0], 1'b0);
    check("push_pop_full_count", cnt_of(0), 16'd4);
    while (model_q.size() > 0) begin
      d = model_q.pop_front();
      check("push_pop_full_order", rd_of(0), {7'h00, d});
      pop(0);
    end
    check("last_pop_was_66", {7'h00, d}, rd_of(0) | 16'h0066);

    // 9-bit, 2 stop bits, oversample 8: reset in the middle of a frame
    drive_bit(2, 1'b0, 8);
    drive_bit(2, 1'b1, 8);
    drive_bit(2, 1'b0, 4);
    @(negedge clk);
    Rst = 1'b0;
    @(negedge clk);
    check("midframe_reset_busy", busy_v[2], 1'b0);
    check("midframe_reset_valid", valid_v[2], 1'b0);
    rx_v[2] = 1'b1;
    @(negedge clk);
    Rst = 1'b1;
    wait_ticks(10);
    send_frame(2, 8, 9, 9'h1AB, 1'b0, 1'b0, 2, 1'b1, 8, 1'b0);
    wait_valid(2, 50);
    check("x1ab_rd_data", rd_of(2), 16'h01AB);
    check("x1ab_fifo_count", cnt_of(2), 16'd1);
    check("x1ab_err_flags", {perr_v[2], ferr_v[2], ovr_v[2]}, 3'b000);
    pop(2);

    // Random 9-bit bursts, ticks every third clock; pointers wrap across bursts
    tick_div = 3;
    for (int b = 0; b < 3; b++) begin
      model_q.delete();
      for (int n = 0; n < 3; n++) begin
        d = 9'($urandom_range(0, 511));
        model_q.push_back(d);
        send_frame(2, 8, 9, d, 1'b0, 1'b0, 2, 1'b1, 8, 1'b0);
      end
      check("burst_count", cnt_of(2), 16'd3);
      while (model_q.size() > 0) begin
        d = model_q.pop_front();
        check("burst_order", rd_of(2), {7'h00, d});
        pop(2);
      end
    end
    check("burst_err_flags", {perr_v[2], ferr_v[2], ovr_v[2]}, 3'b000);
    tick_div = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
